// File: rtl/uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// uart_tx_buffered
//   Byte FIFO in front of an 8N1 serial transmitter. Bit timing comes from an
//   external baud clock (bclk); only its rising edge advances the line.
//
// Ports
//   clk       in   system clock, all state on its rising edge
//   reset     in   asynchronous, active-high reset
//   bclk      in   baud clock, synchronous to clk; rising edge = one bit period
//   wr_en     in   enqueue strobe, one byte per clk when high
//   wr_data   in   byte to enqueue
//   tx_out    out  serial line, idle high, registered
//   busy      out  frame in progress
//   full      out  FIFO holds DEPTH bytes
//   empty     out  FIFO holds no bytes
//   count     out  bytes waiting in the FIFO (the byte being shifted excluded)
//   overflow  out  sticky; a write arrived while full and was dropped
// ---------------------------------------------------------------------------
module uart_tx_buffered #(
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     bclk,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     tx_out,
    output logic                     busy,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Registered state
    state_t          state_q,   state_d;
    logic            tx_q,      tx_d;
    logic            bclk_q,    bclk_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shreg_q,   shreg_d;
    logic [AW-1:0]   wr_ptr_q,  wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q,  rd_ptr_d;
    logic [CW-1:0]   count_q,   count_d;
    logic            ovf_q,     ovf_d;

    // FIFO storage; contents need no reset because the pointers and count do
    logic [7:0]      mem [DEPTH];

    // Combinational helpers
    logic            tick;
    logic            full_c;
    logic            empty_c;
    logic            wr_accept;
    logic            pop;
    logic [2:0]      nxt_bit;

    always_comb begin
        tick      = bclk & ~bclk_q;
        full_c    = (count_q == CNT_FULL);
        empty_c   = (count_q == '0);
        // A write while full is dropped even if a pop frees a slot this cycle
        wr_accept = wr_en & ~full_c;
        // Bytes leave the FIFO only at a frame boundary: from IDLE, or at the
        // end of a stop bit so consecutive frames abut with no idle gap
        pop       = tick & ~empty_c & ((state_q == IDLE) | (state_q == STOP));
        nxt_bit   = bit_cnt_q + 3'd1;

        state_d   = state_q;
        tx_d      = tx_q;
        bclk_d    = bclk;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;   // DEPTH is a power of two: wraps naturally
        end
        if (wr_en & full_c) begin
            ovf_d = 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            shreg_d  = mem[rd_ptr_q];
        end

        case ({wr_accept, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (tick) begin
            case (state_q)
                IDLE: begin
                    tx_d = 1'b1;
                    if (pop) begin
                        tx_d    = 1'b0;
                        state_d = START;
                    end
                end
                START: begin
                    tx_d      = shreg_q[0];
                    bit_cnt_d = 3'd0;
                    state_d   = DATA;
                end
                DATA: begin
                    if (bit_cnt_q != 3'd7) begin
                        tx_d      = shreg_q[nxt_bit];
                        bit_cnt_d = nxt_bit;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end
                end
                STOP: begin
                    if (pop) begin
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    tx_d    = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            tx_q      <= 1'b1;
            bclk_q    <= 1'b0;
            bit_cnt_q <= 3'd0;
            shreg_q   <= 8'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            bclk_q    <= bclk_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign tx_out   = tx_q;
    assign busy     = (state_q != IDLE);
    assign full     = full_c;
    assign empty    = empty_c;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_buffered
//   Directed and randomized stimulus for uart_tx_buffered. The reference model
//   is a byte queue (the FIFO) plus a queue of line bits for the frame on the
//   wire; each bclk rising edge retires one line bit and, once the line queue
//   runs dry, a waiting byte is expanded into its ten 8N1 bits.
// ---------------------------------------------------------------------------
module tb_uart_tx_buffered;

    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       bclk;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx_out;
    logic       busy;
    logic       full;
    logic       empty;
    logic [5:0] count;
    logic       overflow;

    always #5 clk = ~clk;

    uart_tx_buffered #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .bclk     (bclk),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .tx_out   (tx_out),
        .busy     (busy),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    byte unsigned fifo_m[$];
    bit           line_m[$];
    bit           bq_m;
    bit           ovf_m;
    // Line samples taken one clk after each tick while a frame is on the wire
    bit           rx_bits[$];
    byte unsigned sent[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("tx_out",   {31'd0, tx_out},   (line_m.size() != 0) ? {31'd0, line_m[0]} : 32'd1);
        chk("busy",     {31'd0, busy},     (line_m.size() != 0) ? 32'd1 : 32'd0);
        chk("count",    {26'd0, count},    fifo_m.size());
        chk("full",     {31'd0, full},     (fifo_m.size() == DEPTH) ? 32'd1 : 32'd0);
        chk("empty",    {31'd0, empty},    (fifo_m.size() == 0) ? 32'd1 : 32'd0);
        chk("overflow", {31'd0, overflow}, {31'd0, ovf_m});
    endtask

    // One clk cycle with the given inputs, model update, then output check
    task automatic step(input bit w, input byte unsigned d, input bit b);
        bit tick;
        bit full_pre;
        wr_en   = w;
        wr_data = d;
        bclk    = b;
        @(posedge clk);
        tick     = b && !bq_m;
        bq_m     = b;
        full_pre = (fifo_m.size() == DEPTH);
        if (tick) begin
            if (line_m.size() != 0) void'(line_m.pop_front());
            if (line_m.size() == 0 && fifo_m.size() != 0) begin
                byte unsigned x;
                x = fifo_m.pop_front();
                line_m.push_back(1'b0);
                for (int i = 0; i < 8; i++) line_m.push_back(x[i]);
                line_m.push_back(1'b1);
            end
        end
        if (w) begin
            if (full_pre) ovf_m = 1'b1;
            else          fifo_m.push_back(d);
        end
        #1;
        check_all();
        if (tick && line_m.size() != 0) rx_bits.push_back(tx_out);
    endtask

    task automatic tick1(input int gap);
        step(1'b0, 8'd0, 1'b1);
        repeat (gap) step(1'b0, 8'd0, 1'b0);
    endtask

    task automatic write_byte(input byte unsigned d);
        sent.push_back(d);
        step(1'b1, d, 1'b0);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((line_m.size() != 0 || fifo_m.size() != 0) && n < budget) begin
            tick1($urandom_range(1, 3));
            n++;
        end
        if (n == budget) begin
            checks++;
            errors++;
            $error("FAIL drain_timeout: observed %0d ticks, expected fewer", n);
        end
        tick1(2);   // one spare tick: line must stay idle
    endtask

    task automatic decode_check(input string tag, input byte unsigned exp[$]);
        int nf;
        chk({tag, "_len"}, rx_bits.size(), exp.size() * 10);
        nf = (rx_bits.size() / 10 < exp.size()) ? rx_bits.size() / 10 : exp.size();
        for (int k = 0; k < nf; k++) begin
            byte unsigned v;
            for (int j = 0; j < 8; j++) v[j] = rx_bits[10*k + 1 + j];
            chk({tag, "_start"}, {31'd0, rx_bits[10*k]},     32'd0);
            chk({tag, "_data"},  {24'd0, v},                 {24'd0, exp[k]});
            chk({tag, "_stop"},  {31'd0, rx_bits[10*k + 9]}, 32'd1);
        end
    endtask

    task automatic do_reset(input bit rel_bclk);
        reset = 1'b1;
        wr_en = 1'b0;
        bclk  = 1'b0;
        #1;
        fifo_m.delete();
        line_m.delete();
        bq_m  = 1'b0;
        ovf_m = 1'b0;
        check_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        bclk  = rel_bclk;
        reset = 1'b0;
    endtask

    initial begin
        byte unsigned list31[$];
        byte unsigned exp_bytes[$];
        bit           exp030[10];

        reset   = 1'b1;
        bclk    = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'd0;

        // Reset values
        do_reset(1'b0);
        repeat (3) step(1'b0, 8'd0, 1'b0);

        // Single byte 0x05, ten ticks
        exp030 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        rx_bits.delete();
        write_byte(8'h05);
        repeat (10) tick1(3);
        chk("f05_len", rx_bits.size(), 10);
        for (int i = 0; i < 10 && i < rx_bits.size(); i++)
            chk("f05_bit", {31'd0, rx_bits[i]}, {31'd0, exp030[i]});
        tick1(3);   // end of stop bit period
        chk("f05_busy_end",  {31'd0, busy},  32'd0);
        chk("f05_empty_end", {31'd0, empty}, 32'd1);

        // 18 bytes back to back
        list31 = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd2, 8'd3, 8'd4, 8'd3,
                   8'd2, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd8, 8'd6, 8'd7};
        rx_bits.delete();
        foreach (list31[i]) write_byte(list31[i]);
        drain(400);
        decode_check("burst18", list31);

        // Overflow with ticks stopped: 33 writes, first 32 kept
        rx_bits.delete();
        sent.delete();
        for (int i = 0; i < 33; i++) write_byte(8'($urandom));
        chk("ovf_full",  {31'd0, full},     32'd1);
        chk("ovf_count", {26'd0, count},    32'd32);
        chk("ovf_flag",  {31'd0, overflow}, 32'd1);
        exp_bytes = sent[0:31];
        drain(700);
        decode_check("ovf32", exp_bytes);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Write on the STOP tick that pops the last queued byte
        do_reset(1'b0);
        rx_bits.delete();
        sent.delete();
        write_byte(8'hA3);
        write_byte(8'h5C);
        tick1(2);                       // pops A3, count 1
        repeat (9) tick1(2);            // now in the stop bit of A3
        chk("stop_count_pre", {26'd0, count}, 32'd1);
        sent.push_back(8'hE7);
        step(1'b1, 8'hE7, 1'b1);        // tick pops 5C while E7 is written
        chk("stop_count_post", {26'd0, count}, 32'd1);
        drain(100);
        decode_check("popwr", sent);

        // bclk held high with one byte queued: a single start bit
        rx_bits.delete();
        sent.delete();
        write_byte(8'h96);
        repeat (50) step(1'b0, 8'd0, 1'b1);
        chk("hold_tx",    {31'd0, tx_out}, 32'd0);
        chk("hold_busy",  {31'd0, busy},   32'd1);
        chk("hold_ticks", rx_bits.size(),  1);
        step(1'b0, 8'd0, 1'b0);
        drain(50);
        decode_check("hold", sent);

        // Randomized traffic: quiet phase, then bursty phase that overfills
        do_reset(1'b0);
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 39) == 0, 8'($urandom), $urandom_range(0, 3) == 0);
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 3) == 0);
        drain(700);

        // Reset during data bit 4 with one byte still queued
        do_reset(1'b0);
        write_byte(8'hC9);
        write_byte(8'h3D);
        repeat (6) tick1(3);            // start, bits 0..4
        chk("pre_rst_count", {26'd0, count}, 32'd1);
        do_reset(1'b1);                 // bclk high at release gives a tick
        for (int i = 0; i < 20; i++) begin
            tick1(2);
            chk("post_rst_idle", {31'd0, tx_out}, 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
